occupancy_grid_updater: RTL

OCCUPANCY_GRID_UPDATER -- requirements
Module: occupancy_grid_updater

---
 rtl/occupancy_grid_updater.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/occupancy_grid_updater.sv
// occupancy_grid_updater
//
// Read-modify-write engine for an 8-bit-per-cell occupancy grid of 32768 cells
// held in an external single-port RAM that has one cycle of read latency.
// A hit adds HIT_INC to the cell and saturates at 255. A miss subtracts
// MISS_DEC from the cell and saturates at 0. A clear writes INIT_VALUE into
// every cell, one cell per cycle.
//
// Ports
//   clock            : single clock, rising edge
//   reset            : synchronous, active-high; starts a full clear sweep
//   clear_request    : one-cycle pulse requesting a full-grid clear
//   update_valid     : update request present
//   update_ready     : request accepted this cycle (IDLE with no clear pending)
//   update_address   : cell index of the request
//   update_hit       : 1 = hit (increment), 0 = miss (decrement)
//   update_done      : one-cycle pulse in the write-back cycle
//   done_value       : value written back; held until the next update_done
//   clear_busy       : high while the clear sweep runs
//   ram_address      : RAM cell address
//   ram_write_enable : RAM write strobe
//   ram_write_data   : RAM write data
//   ram_read_data    : RAM read data, valid one cycle after ram_address
module occupancy_grid_updater #(
  parameter int unsigned HIT_INC    = 8,
  parameter int unsigned MISS_DEC   = 4,
  parameter int unsigned INIT_VALUE = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_request,
  input  logic        update_valid,
  output logic        update_ready,
  input  logic [14:0] update_address,
  input  logic        update_hit,
  output logic        update_done,
  output logic [7:0]  done_value,
  output logic        clear_busy,
  output logic [14:0] ram_address,
  output logic        ram_write_enable,
  output logic [7:0]  ram_write_data,
  input  logic [7:0]  ram_read_data
);

  localparam logic [1:0] StClear = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;
  localparam logic [1:0] StWrite = 2'd3;

  localparam logic [7:0] InitByte = 8'(INIT_VALUE);

  logic [1:0]  state_q, state_d;
  logic [14:0] sweep_q, sweep_d;
  logic        pending_q, pending_d;
  logic [14:0] addr_q, addr_d;
  logic        hit_q, hit_d;
  logic [7:0]  done_value_q, done_value_d;

  logic        clear_pending;
  logic [31:0] read_ext;
  logic [31:0] hit_sum;
  logic [7:0]  new_value;

  // A request arriving in the same IDLE cycle counts as pending, so it wins
  // over update_valid and pulls update_ready low immediately.
  assign clear_pending = pending_q | clear_request;

  // Arithmetic is done at 32 bits so the saturation tests see the true result.
  always_comb begin
    read_ext = {24'd0, ram_read_data};
    hit_sum  = read_ext + HIT_INC;
    if (hit_q) begin
      new_value = (hit_sum > 32'd255) ? 8'hff : 8'(hit_sum);
    end else begin
      new_value = (read_ext < MISS_DEC) ? 8'h00 : 8'(read_ext - MISS_DEC);
    end
  end

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    hit_d        = hit_q;
    done_value_d = done_value_q;
    unique case (state_q)
      StClear: begin
        // Counter wraps to 0 after the last cell, ready for the next sweep.
        sweep_d = sweep_q + 15'd1;
        if (&sweep_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (clear_pending) begin
          state_d   = StClear;
          sweep_d   = 15'd0;
          pending_d = 1'b0;
        end else if (update_valid) begin
          addr_d  = update_address;
          hit_d   = update_hit;
          state_d = StRead;
        end
      end
      StRead: begin
        if (clear_request) begin
          pending_d = 1'b1;
        end
        state_d = StWrite;
      end
      StWrite: begin
        if (clear_request) begin
          pending_d = 1'b1;
        end
        done_value_d = new_value;
        state_d      = StIdle;
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StClear;
      sweep_q      <= 15'd0;
      pending_q    <= 1'b0;
      addr_q       <= 15'd0;
      hit_q        <= 1'b0;
      done_value_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      pending_q    <= pending_d;
      addr_q       <= addr_d;
      hit_q        <= hit_d;
      done_value_q <= done_value_d;
    end
  end

  always_comb begin
    clear_busy       = (state_q == StClear);
    update_ready     = (state_q == StIdle) && !clear_pending;
    update_done      = (state_q == StWrite);
    ram_write_enable = (state_q == StClear) || (state_q == StWrite);
    ram_address      = (state_q == StClear) ? sweep_q : addr_q;
    if (state_q == StClear) begin
      ram_write_data = InitByte;
    end else if (state_q == StWrite) begin
      ram_write_data = new_value;
    end else begin
      ram_write_data = 8'd0;
    end
    // The written value is visible in the write-back cycle itself.
    done_value = (state_q == StWrite) ? new_value : done_value_q;
  end

endmodule
